// File: rtl/mem_pkg.sv
// Shared definitions for the memory access protocol: responder FSM state
// encoding and the operation codes carried on wr_rd_i. Also used by the
// memory test sequencer, so the encodings here are fixed.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic OP_WR = 1'b1;
  localparam logic OP_RD = 1'b0;

endpackage

// File: rtl/mem_responder_if.sv
// Single-port valid/ready memory access bus.
// Signal names are taken from the responder's point of view.
//   valid_i  : request valid, held with all request fields until ready_o
//   wr_rd_i  : 1 = write, 0 = read
//   addr_i   : word address
//   wdata_i  : write data
//   rdata_o  : read data, valid with ready_o on a read, then held
//   ready_o  : one-cycle completion pulse
//   err_o    : out-of-range flag, only ever high together with ready_o
// Handshake: the initiator raises valid_i and holds it and every request
// field stable until it sees ready_o=1; the transfer completes in that
// ready_o cycle. The responder looks at valid_i only while idle.
interface mem_responder_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 6
);
  logic                  valid_i;
  logic                  wr_rd_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [WIDTH-1:0]      wdata_i;
  logic [WIDTH-1:0]      rdata_o;
  logic                  ready_o;
  logic                  err_o;

  modport master (
    output valid_i, wr_rd_i, addr_i, wdata_i,
    input  rdata_o, ready_o, err_o
  );

  modport slave (
    input  valid_i, wr_rd_i, addr_i, wdata_i,
    output rdata_o, ready_o, err_o
  );
endinterface

// File: rtl/mem_resp_array.sv
// DEPTH x WIDTH storage for the memory responder.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset (clears every word)
//   we_i, waddr_i, wdata_i : single write port
//   re_i, rzero_i, raddr_i : registered read port; rzero_i loads zero instead
//                            of a word (used for out-of-range reads)
//   rdata_o      : read register, holds until the next read
module mem_resp_array #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  re_i,
  input  logic                  rzero_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= rzero_i ? '0 : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Responder end of the valid/ready memory access protocol. Accepts one
// request at a time, waits WAIT_STATES cycles, then completes it with a
// one-cycle ready_o pulse (err_o alongside for addresses >= DEPTH).
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : mem_responder_if slave modport (request in, response out)
//   wr_cnt_o     : completed in-range writes, saturating
//   rd_cnt_o     : completed in-range reads, saturating
//   state_o      : current FSM state (debug)
module mem_responder
  import mem_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 64,
  parameter int ADDR_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int WAIT_STATES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  mem_responder_if.slave       bus,
  output logic [CNT_WIDTH-1:0] wr_cnt_o,
  output logic [CNT_WIDTH-1:0] rd_cnt_o,
  output state_e               state_o
);

  state_e                state_q, state_d;
  logic [7:0]            wait_q, wait_d;
  logic                  op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      wdata_q;
  logic                  ready_q, err_q;
  logic [CNT_WIDTH-1:0]  wr_cnt_q, rd_cnt_q;

  logic                  accept, enter_resp;
  logic                  cur_op, cur_oob;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [WIDTH-1:0]      cur_wdata;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          wait_d  = 8'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        wait_d = wait_q - 8'd1;
        if (wait_q <= 8'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept     = (state_q == IDLE) && bus.valid_i;
  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  // With zero wait states the request goes straight from IDLE to RESP, so the
  // latched copies are not yet valid on that edge; use the live bus instead.
  assign cur_op    = (state_q == IDLE) ? bus.wr_rd_i : op_q;
  assign cur_addr  = (state_q == IDLE) ? bus.addr_i  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? bus.wdata_i : wdata_q;
  assign cur_oob   = (32'(cur_addr) >= DEPTH);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      op_q     <= OP_RD;
      addr_q   <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (accept) begin
        op_q    <= bus.wr_rd_i;
        addr_q  <= bus.addr_i;
        wdata_q <= bus.wdata_i;
      end
      ready_q <= enter_resp;
      err_q   <= enter_resp && cur_oob;
      if (enter_resp && !cur_oob) begin
        if (cur_op == OP_WR && wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 1'b1;
        if (cur_op == OP_RD && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 1'b1;
      end
    end
  end

  mem_resp_array #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (enter_resp && cur_op == OP_WR && !cur_oob),
    .waddr_i(cur_addr),
    .wdata_i(cur_wdata),
    .re_i   (enter_resp && cur_op == OP_RD),
    .rzero_i(cur_oob),
    .raddr_i(cur_addr),
    .rdata_o(bus.rdata_o)
  );

  assign bus.ready_o = ready_q;
  assign bus.err_o   = err_q;
  assign wr_cnt_o    = wr_cnt_q;
  assign rd_cnt_o    = rd_cnt_q;
  assign state_o     = state_q;

endmodule
